// File: rtl/ddr5_pkg.sv
// Shared types, timing defaults and small helpers for the DDR5 command responder.
package ddr5_pkg;

  localparam int N_BG    = 8;
  localparam int N_BA    = 4;
  localparam int N_BANK  = N_BG * N_BA;
  localparam int T_RCD   = 39;
  localparam int T_RP    = 39;
  localparam int T_RAS   = 76;
  localparam int T_CAS   = 40;
  localparam int T_CWD   = 38;
  localparam int T_BURST = 8;

  typedef enum logic [2:0] {
    CMD_ACT0 = 3'd0,
    CMD_ACT1 = 3'd1,
    CMD_RD0  = 3'd2,
    CMD_RD1  = 3'd3,
    CMD_WR0  = 3'd4,
    CMD_WR1  = 3'd5,
    CMD_PRE  = 3'd6,
    CMD_NOP  = 3'd7
  } cmd_t;

  typedef enum logic [2:0] {
    ERR_NONE     = 3'd0,
    ERR_PROTO    = 3'd1,
    ERR_CLOSED   = 3'd2,
    ERR_ACT_OPEN = 3'd3,
    ERR_TRCD     = 3'd4,
    ERR_TRP      = 3'd5,
    ERR_TRAS     = 3'd6,
    ERR_BUS      = 3'd7
  } err_t;

  typedef enum logic {
    BANK_IDLE   = 1'b0,
    BANK_ACTIVE = 1'b1
  } bank_state_t;

  typedef struct packed {
    logic       wr;
    logic [2:0] bg;
    logic [1:0] ba;
    logic [9:0] col;
  } burst_t;

  function automatic logic [4:0] bank_idx(input logic [2:0] bg, input logic [1:0] ba);
    return {bg, ba};
  endfunction

  // Second phase that must follow a given first phase.
  function automatic cmd_t phase1_of(input cmd_t c);
    case (c)
      CMD_ACT0: return CMD_ACT1;
      CMD_RD0:  return CMD_RD1;
      CMD_WR0:  return CMD_WR1;
      default:  return CMD_NOP;
    endcase
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/ddr5_cmd_responder_if.sv
// Command stream in, data-burst / bank-state / error status out.
interface ddr5_cmd_responder_if;
  import ddr5_pkg::*;

  logic        cmd_valid;
  cmd_t        cmd;
  logic [2:0]  cmd_bg;
  logic [1:0]  cmd_ba;
  logic [15:0] cmd_row;
  logic [9:0]  cmd_col;

  logic        rd_valid;
  logic        wr_req;
  logic [2:0]  dq_bg;
  logic [1:0]  dq_ba;
  logic [9:0]  dq_col;
  logic [2:0]  dq_beat;
  logic [31:0] bank_open;
  logic        err_valid;
  err_t        err_code;

  modport master (
    output cmd_valid, cmd, cmd_bg, cmd_ba, cmd_row, cmd_col,
    input  rd_valid, wr_req, dq_bg, dq_ba, dq_col, dq_beat, bank_open, err_valid, err_code
  );

  modport slave (
    input  cmd_valid, cmd, cmd_bg, cmd_ba, cmd_row, cmd_col,
    output rd_valid, wr_req, dq_bg, dq_ba, dq_col, dq_beat, bank_open, err_valid, err_code
  );

endinterface

// File: rtl/ddr5_bank_tracker.sv
// One bank: open/closed state, open row, and activate/precharge timers.
//   state       | meaning
//   BANK_IDLE   | precharged, rp_cnt counts time since PRE
//   BANK_ACTIVE | row open, ras_cnt counts time since ACT1
// The accepting cycle counts as 0, so a timer reads 1 on the following cycle and
// reads N exactly N cycles after the command. Both timers saturate at 255.
module ddr5_bank_tracker
  import ddr5_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        act_ok,
  input  logic        pre_ok,
  input  logic [15:0] act_row,
  output logic        is_open,
  output logic        rcd_met,
  output logic        ras_met,
  output logic        rp_met
);

  bank_state_t state;
  logic [15:0] row_q;
  logic [7:0]  ras_cnt;
  logic [7:0]  rp_cnt;

  // Bank FSM plus its timers; timers start saturated so the bank is usable right after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= BANK_IDLE;
      row_q   <= '0;
      ras_cnt <= 8'hFF;
      rp_cnt  <= 8'hFF;
    end else begin
      ras_cnt <= sat_inc(ras_cnt);
      rp_cnt  <= sat_inc(rp_cnt);
      case (state)
        BANK_IDLE: if (act_ok) begin
          state   <= BANK_ACTIVE;
          row_q   <= act_row;
          ras_cnt <= 8'd1;
        end
        BANK_ACTIVE: if (pre_ok) begin
          state  <= BANK_IDLE;
          rp_cnt <= 8'd1;
        end
        default: state <= BANK_IDLE;
      endcase
    end
  end

  assign is_open = (state == BANK_ACTIVE);
  assign rcd_met = (ras_cnt >= 8'(T_RCD));
  assign ras_met = (ras_cnt >= 8'(T_RAS));
  assign rp_met  = (rp_cnt  >= 8'(T_RP));

  a_row_capture: assert property (@(posedge clk) disable iff (!rst_n)
    (state == BANK_IDLE && act_ok) |=> (row_q == $past(act_row)));

endmodule

// File: rtl/ddr5_cmd_responder.sv
// DIMM-side responder: pairs two-phase commands, checks bank timing and bus
// ownership, and plays back read / write-data-request bursts.
module ddr5_cmd_responder
  import ddr5_pkg::*;
(
  input logic                 clk,
  input logic                 rst_n,
  ddr5_cmd_responder_if.slave bus
);

  logic              pend_valid;
  cmd_t              pend_cmd;
  logic [2:0]        pend_bg;
  logic [1:0]        pend_ba;
  logic [N_BANK-1:0] open_vec, rcd_met, ras_met, rp_met;
  logic [4:0]        cmd_idx;
  logic              phase1, pre_phase, pend_set, do_act, do_pre, do_burst, bus_busy;
  err_t              err_nxt;
  logic [5:0]        lat;
  logic [1:0]        slot_v;
  logic [5:0]        slot_rem [2];
  burst_t            slot_info [2];
  logic              hit0, hit1, sel, alloc;

  // slot_rem is the distance in cycles to a burst's last beat, so its window is
  // [rem-7, rem] relative to now; a new burst occupies [lat, lat+7].
  function automatic logic overlaps(input logic v, input logic [5:0] rem, input logic [5:0] l);
    return v && (rem >= l) && (rem <= l + 6'(2 * T_BURST - 2));
  endfunction

  assign cmd_idx  = bank_idx(bus.cmd_bg, bus.cmd_ba);
  assign lat      = (bus.cmd == CMD_WR1) ? 6'(T_CWD) : 6'(T_CAS);
  assign bus_busy = (&slot_v) || overlaps(slot_v[0], slot_rem[0], lat)
                              || overlaps(slot_v[1], slot_rem[1], lat);
  assign alloc    = slot_v[0];

  for (genvar g = 0; g < N_BANK; g++) begin : g_bank
    ddr5_bank_tracker u_bank (
      .clk     (clk),
      .rst_n   (rst_n),
      .act_ok  (do_act && (cmd_idx == 5'(g))),
      .pre_ok  (do_pre && (cmd_idx == 5'(g))),
      .act_row (bus.cmd_row),
      .is_open (open_vec[g]),
      .rcd_met (rcd_met[g]),
      .ras_met (ras_met[g]),
      .rp_met  (rp_met[g])
    );
  end

  // Decode: phase pairing first, then legality; checks are ordered so the lowest code wins.
  always_comb begin
    err_nxt   = ERR_NONE;
    pend_set  = 1'b0;
    phase1    = 1'b0;
    pre_phase = 1'b0;
    do_act    = 1'b0;
    do_pre    = 1'b0;
    do_burst  = 1'b0;
    if (pend_valid) begin
      if (bus.cmd_valid && bus.cmd == phase1_of(pend_cmd) &&
          bus.cmd_bg == pend_bg && bus.cmd_ba == pend_ba)
        phase1 = 1'b1;
      else
        err_nxt = ERR_PROTO;
    end else if (bus.cmd_valid) begin
      case (bus.cmd)
        CMD_ACT0, CMD_RD0, CMD_WR0: pend_set  = 1'b1;
        CMD_PRE:                    pre_phase = 1'b1;
        default:                    err_nxt   = ERR_PROTO;
      endcase
    end
    if (phase1) begin
      if (bus.cmd == CMD_ACT1) begin
        if (open_vec[cmd_idx])     err_nxt = ERR_ACT_OPEN;
        else if (!rp_met[cmd_idx]) err_nxt = ERR_TRP;
        else                       do_act  = 1'b1;
      end else begin
        if (!open_vec[cmd_idx])     err_nxt  = ERR_CLOSED;
        else if (!rcd_met[cmd_idx]) err_nxt  = ERR_TRCD;
        else if (bus_busy)          err_nxt  = ERR_BUS;
        else                        do_burst = 1'b1;
      end
    end
    if (pre_phase && open_vec[cmd_idx]) begin
      if (!ras_met[cmd_idx]) err_nxt = ERR_TRAS;
      else                   do_pre  = 1'b1;
    end
  end

  // First-phase register; any cycle with a phase pending consumes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_valid <= 1'b0;
      pend_cmd   <= CMD_NOP;
      pend_bg    <= '0;
      pend_ba    <= '0;
    end else begin
      pend_valid <= pend_set;
      if (pend_set) begin
        pend_cmd <= bus.cmd;
        pend_bg  <= bus.cmd_bg;
        pend_ba  <= bus.cmd_ba;
      end
    end
  end

  // Registered one-cycle error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.err_valid <= 1'b0;
      bus.err_code  <= ERR_NONE;
    end else begin
      bus.err_valid <= (err_nxt != ERR_NONE);
      bus.err_code  <= err_nxt;
    end
  end

  // Two burst slots (one waiting, one playing) counting down to their last beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_v <= '0;
      for (int s = 0; s < 2; s++) begin
        slot_rem[s]  <= '0;
        slot_info[s] <= '0;
      end
    end else begin
      for (int s = 0; s < 2; s++) begin
        if (slot_v[s]) begin
          if (slot_rem[s] == 6'd0) slot_v[s] <= 1'b0;
          else                     slot_rem[s] <= slot_rem[s] - 6'd1;
        end else if (do_burst && alloc == 1'(s)) begin
          slot_v[s]    <= 1'b1;
          slot_rem[s]  <= lat + 6'(T_BURST - 2);
          slot_info[s] <= '{wr: (bus.cmd == CMD_WR1), bg: bus.cmd_bg, ba: bus.cmd_ba, col: bus.cmd_col};
        end
      end
    end
  end

  // Beat outputs from whichever slot is inside its window (windows never overlap).
  always_comb begin
    hit0        = slot_v[0] && (slot_rem[0] < 6'(T_BURST));
    hit1        = slot_v[1] && (slot_rem[1] < 6'(T_BURST));
    sel         = !hit0;
    bus.rd_valid = 1'b0;
    bus.wr_req   = 1'b0;
    bus.dq_bg    = '0;
    bus.dq_ba    = '0;
    bus.dq_col   = '0;
    bus.dq_beat  = '0;
    if (hit0 || hit1) begin
      bus.rd_valid = !slot_info[sel].wr;
      bus.wr_req   = slot_info[sel].wr;
      bus.dq_bg    = slot_info[sel].bg;
      bus.dq_ba    = slot_info[sel].ba;
      bus.dq_col   = slot_info[sel].col;
      bus.dq_beat  = 3'(T_BURST - 1) - slot_rem[sel][2:0];
    end
  end

  assign bus.bank_open = open_vec;

endmodule

// File: tb/tb_ddr5_cmd_responder.sv
// Scoreboard bench: expected error pulses and data beats are queued as commands are
// driven and retired by a monitor on the falling edge.
module tb_ddr5_cmd_responder;
  import ddr5_pkg::*;

  typedef struct packed {
    logic [31:0] cyc;
    logic [2:0]  code;
  } err_exp_t;

  typedef struct packed {
    logic [31:0] cyc;
    logic        wr;
    logic [2:0]  bg;
    logic [1:0]  ba;
    logic [9:0]  col;
    logic [2:0]  beat;
  } beat_exp_t;

  logic clk;
  logic rst_n;
  int   cyc = 0;
  int   last_cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  err_exp_t  err_q[$];
  beat_exp_t beat_q[$];

  ddr5_cmd_responder_if bus();

  ddr5_cmd_responder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_until(input int n);
    while (cyc < n) step();
  endtask

  task automatic drive(input cmd_t c, input logic [2:0] bg, input logic [1:0] ba,
                       input logic [15:0] row, input logic [9:0] col);
    last_cyc      = cyc;
    bus.cmd_valid = 1'b1;
    bus.cmd       = c;
    bus.cmd_bg    = bg;
    bus.cmd_ba    = ba;
    bus.cmd_row   = row;
    bus.cmd_col   = col;
    step();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic push_err(input err_t code, input int at);
    err_q.push_back('{cyc: 32'(at), code: code});
  endtask

  task automatic push_burst(input logic wr, input logic [2:0] bg, input logic [1:0] ba,
                            input logic [9:0] col, input int t);
    int l;
    l = wr ? T_CWD : T_CAS;
    for (int i = 0; i < T_BURST; i++)
      beat_q.push_back('{cyc: 32'(t + l + i), wr: wr, bg: bg, ba: ba, col: col, beat: 3'(i)});
  endtask

  // Retire queued expectations as the DUT produces pulses and beats.
  always @(negedge clk) begin
    err_exp_t  e;
    beat_exp_t b;
    beat_exp_t o;
    if (rst_n) begin
      if (bus.err_valid) begin
        if (err_q.size() == 0) begin
          check_eq("err_extra", 64'({32'(cyc), bus.err_code}), 64'(0));
        end else begin
          e = err_q.pop_front();
          check_eq("err", 64'({32'(cyc), bus.err_code}), 64'(e));
        end
      end
      if (bus.rd_valid || bus.wr_req) begin
        o = '{cyc: 32'(cyc), wr: bus.wr_req, bg: bus.dq_bg, ba: bus.dq_ba, col: bus.dq_col, beat: bus.dq_beat};
        if (beat_q.size() == 0) begin
          check_eq("beat_extra", 64'(o), 64'(0));
        end else begin
          b = beat_q.pop_front();
          check_eq("beat", 64'(o), 64'(b));
        end
      end
    end
  end

  initial begin
    int a, b, p, q, p2, t, r;
    rst_n         = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd       = CMD_NOP;
    bus.cmd_bg    = '0;
    bus.cmd_ba    = '0;
    bus.cmd_row   = '0;
    bus.cmd_col   = '0;
    repeat (3) step();
    check_eq("rst_open", 64'(bus.bank_open), 64'(0));
    check_eq("rst_out", 64'({bus.rd_valid, bus.wr_req, bus.err_valid, bus.err_code}), 64'(0));
    rst_n = 1'b1;
    step();

    // Activate then read at exactly tRCD.
    drive(CMD_ACT0, 3'd2, 2'd1, 16'h1A2B, 10'd0);
    drive(CMD_ACT1, 3'd2, 2'd1, 16'h1A2B, 10'd0);
    a = last_cyc;
    check_eq("t1_open", 64'(bus.bank_open), 64'h200);
    idle_until(a + 38);
    drive(CMD_RD0, 3'd2, 2'd1, 16'd0, 10'h3F);
    drive(CMD_RD1, 3'd2, 2'd1, 16'd0, 10'h3F);
    push_burst(1'b0, 3'd2, 2'd1, 10'h3F, last_cyc);

    // Read one cycle short of tRCD.
    drive(CMD_ACT0, 3'd0, 2'd0, 16'h0005, 10'd0);
    drive(CMD_ACT1, 3'd0, 2'd0, 16'h0005, 10'd0);
    b = last_cyc;
    idle_until(b + 37);
    drive(CMD_RD0, 3'd0, 2'd0, 16'd0, 10'h10);
    drive(CMD_RD1, 3'd0, 2'd0, 16'd0, 10'h10);
    push_err(ERR_TRCD, last_cyc + 1);
    check_eq("t2_open", 64'(bus.bank_open), 64'h201);

    // tRAS boundary, then tRP boundary on both sides.
    idle_until(b + 75);
    drive(CMD_PRE, 3'd0, 2'd0, 16'd0, 10'd0);
    push_err(ERR_TRAS, last_cyc + 1);
    check_eq("t3_tras_open", 64'(bus.bank_open), 64'h201);
    drive(CMD_PRE, 3'd0, 2'd0, 16'd0, 10'd0);
    p = last_cyc;
    check_eq("t3_pre", 64'(bus.bank_open), 64'h200);
    idle_until(p + 37);
    drive(CMD_ACT0, 3'd0, 2'd0, 16'h0006, 10'd0);
    drive(CMD_ACT1, 3'd0, 2'd0, 16'h0006, 10'd0);
    push_err(ERR_TRP, last_cyc + 1);
    check_eq("t3_trp_idle", 64'(bus.bank_open), 64'h200);
    drive(CMD_ACT0, 3'd0, 2'd0, 16'h0007, 10'd0);
    drive(CMD_ACT1, 3'd0, 2'd0, 16'h0007, 10'd0);
    q = last_cyc;
    check_eq("t3_reopen", 64'(bus.bank_open), 64'h201);
    idle_until(q + 76);
    drive(CMD_PRE, 3'd0, 2'd0, 16'd0, 10'd0);
    p2 = last_cyc;
    check_eq("t3_pre2", 64'(bus.bank_open), 64'h200);
    idle_until(p2 + 38);
    drive(CMD_ACT0, 3'd0, 2'd0, 16'h0008, 10'd0);
    drive(CMD_ACT1, 3'd0, 2'd0, 16'h0008, 10'd0);
    check_eq("t3_trp_ok", 64'(bus.bank_open), 64'h201);

    // Protocol errors, closed bank, double activate, precharge of an idle bank.
    drive(CMD_ACT0, 3'd5, 2'd3, 16'h0100, 10'd0);
    step();
    push_err(ERR_PROTO, last_cyc + 2);
    drive(CMD_ACT0, 3'd5, 2'd3, 16'h0101, 10'd0);
    drive(CMD_ACT1, 3'd5, 2'd2, 16'h0101, 10'd0);
    push_err(ERR_PROTO, last_cyc + 1);
    drive(CMD_RD1, 3'd5, 2'd3, 16'd0, 10'd1);
    push_err(ERR_PROTO, last_cyc + 1);
    check_eq("t4_idle", 64'(bus.bank_open), 64'h201);
    drive(CMD_RD0, 3'd5, 2'd3, 16'd0, 10'd2);
    drive(CMD_RD1, 3'd5, 2'd3, 16'd0, 10'd2);
    push_err(ERR_CLOSED, last_cyc + 1);
    drive(CMD_ACT0, 3'd2, 2'd1, 16'h0200, 10'd0);
    drive(CMD_ACT1, 3'd2, 2'd1, 16'h0200, 10'd0);
    push_err(ERR_ACT_OPEN, last_cyc + 1);
    drive(CMD_PRE, 3'd7, 2'd0, 16'd0, 10'd0);
    step();
    check_eq("t4_final", 64'(bus.bank_open), 64'h201);

    // Data-bus ownership: overlap, back-to-back, and slot exhaustion.
    idle_until(cyc + 100);
    drive(CMD_WR0, 3'd2, 2'd1, 16'd0, 10'h2A);
    drive(CMD_WR1, 3'd2, 2'd1, 16'd0, 10'h2A);
    t = last_cyc;
    push_burst(1'b1, 3'd2, 2'd1, 10'h2A, t);
    drive(CMD_RD0, 3'd2, 2'd1, 16'd0, 10'h11);
    drive(CMD_RD1, 3'd2, 2'd1, 16'd0, 10'h11);
    push_err(ERR_BUS, last_cyc + 1);
    idle_until(t + 5);
    drive(CMD_RD0, 3'd0, 2'd0, 16'd0, 10'h55);
    drive(CMD_RD1, 3'd0, 2'd0, 16'd0, 10'h55);
    push_burst(1'b0, 3'd0, 2'd0, 10'h55, last_cyc);
    idle_until(t + 19);
    drive(CMD_WR0, 3'd2, 2'd1, 16'd0, 10'h66);
    drive(CMD_WR1, 3'd2, 2'd1, 16'd0, 10'h66);
    push_err(ERR_BUS, last_cyc + 1);

    // Reset in the middle of a read burst.
    idle_until(t + 70);
    drive(CMD_RD0, 3'd2, 2'd1, 16'd0, 10'h77);
    drive(CMD_RD1, 3'd2, 2'd1, 16'd0, 10'h77);
    r = last_cyc;
    push_burst(1'b0, 3'd2, 2'd1, 10'h77, r);
    idle_until(r + 44);
    rst_n = 1'b0;
    #1;
    check_eq("t6_rd_drop", 64'({bus.rd_valid, bus.wr_req}), 64'(0));
    check_eq("t6_open", 64'(bus.bank_open), 64'(0));
    check_eq("t6_beats_cut", 64'(beat_q.size()), 64'(4));
    beat_q.delete();
    step();
    step();
    rst_n = 1'b1;
    drive(CMD_ACT0, 3'd2, 2'd1, 16'h0300, 10'd0);
    drive(CMD_ACT1, 3'd2, 2'd1, 16'h0300, 10'd0);
    check_eq("t6_act", 64'(bus.bank_open), 64'h200);

    repeat (60) step();
    check_eq("err_q_left", 64'(err_q.size()), 64'(0));
    check_eq("beat_q_left", 64'(beat_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
